// File: rtl/gate_input_debouncer_pkg.sv
// Shared definitions for the gate input debouncer: default debounce length,
// counter-width helper and the per-channel edge pulse pair.
package gate_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 4;

  // Smallest counter width that can hold STABLE_CYCLES-1 without wrapping.
  function automatic int min_cnt_width(input int stable_cycles);
    if (stable_cycles <= 2) return 1;
    return $clog2(stable_cycles);
  endfunction

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

endpackage

// File: rtl/gate_input_debouncer_channel.sv
// One debounce lane: 2-flop synchroniser, stability counter, registered
// debounced level with matching rise/fall pulses and a combinational idle flag.
module debounce_channel
  import gate_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic out,
  output logic rise,
  output logic fall,
  output logic idle
);

  generate
    if (STABLE_CYCLES < 1 || CNT_W < min_cnt_width(STABLE_CYCLES)) begin : g_bad_params
      $error("debounce_channel: STABLE_CYCLES must be >= 1 and CNT_W wide enough for STABLE_CYCLES-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  edge_t            edge_q;

  // The >= compare keeps the counter capped so it can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      out    <= 1'b0;
      edge_q <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      edge_q <= '0;
      if (s2 == out) begin
        cnt <= '0;
      end else if (cnt >= LAST) begin
        out         <= s2;
        cnt         <= '0;
        edge_q.rise <= s2;
        edge_q.fall <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise = edge_q.rise;
  assign fall = edge_q.fall;
  assign idle = (s2 == out) && (cnt == '0);

endmodule

// File: rtl/gate_input_debouncer.sv
// Two independent debounce lanes feeding and_gate, plus a registered flag
// that reports when both lanes are quiet.
module gate_input_debouncer
  import gate_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_A,
  input  logic raw_B,
  output logic A,
  output logic B,
  output logic A_rise,
  output logic A_fall,
  output logic B_rise,
  output logic B_fall,
  output logic settled
);

  logic idle_a;
  logic idle_b;

  debounce_channel #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_chan_a (
    .clk (clk),
    .rst (rst),
    .raw (raw_A),
    .out (A),
    .rise(A_rise),
    .fall(A_fall),
    .idle(idle_a)
  );

  debounce_channel #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_chan_b (
    .clk (clk),
    .rst (rst),
    .raw (raw_B),
    .out (B),
    .rise(B_rise),
    .fall(B_fall),
    .idle(idle_b)
  );

  always_ff @(posedge clk) begin
    if (rst) settled <= 1'b0;
    else     settled <= idle_a && idle_b;
  end

endmodule
